dl_rr_arb32: RTL
================

Name: dl_rr_arb32

Overview:
- Round-robin arbiter and sequencer that shares one 32-input datapath multiplexer among 32 requesters.
- Produces the 5-bit mux select plus a one-hot grant.
- Holds each grant for a multi-beat transfer until the requester's last beat is accepted downstream, the requester withdraws, or a burst-length cap forces re-arbitration.
- Sits between the requester interfaces and the shared 32-to-1 mux feeding a single downstream consumer (e.g. register-file write port or shared bus).

Parameters:
- NUM_REQ, 32, number of requesters; fixed at 32 to match the 5-bit mux select (other values unsupported).
- SEL_BITS, 5, select width; must equal log2(NUM_REQ).
- HOLD_MAX, 16, max accepted beats per grant before forced release; legal range 1..256.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  32  per-requester request/valid; bit i high means requester i has a beat pending.
- req_last  input  32  per-requester last-beat flag; sampled only for the granted requester.
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  32  one-hot grant, registered; all zero when not locked.
- sel  output  5  mux select, registered; index of granted requester.
- out_valid  output  1  high when locked AND req[sel].
- out_last  output  1  high when locked AND req_last[sel].
- locked  output  1  high in state LOCKED.
- hold_expired  output  1  one-cycle pulse, registered, when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, ptr=0, gnt=0, sel=0, beat_cnt=0, hold_expired=0. Combinational outputs follow, so out_valid=0, out_last=0, locked=0.
- Reset mid-burst aborts the grant immediately. No beat is completed afterwards.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise the winner w is the first index i with req[i]=1, searching ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
  - Next cycle: state=LOCKED, sel=w, gnt=1<<w, beat_cnt=0.
  - Grant latency: one cycle from req assertion in IDLE.
- State LOCKED:
  - gnt and sel stay stable for the whole state.
  - A beat is accepted on a cycle where out_valid=1 and out_ready=1. Each accepted beat increments beat_cnt (8-bit, never wraps because release occurs at HOLD_MAX).
  - Release conditions, evaluated per cycle:
    - (a) accepted beat with req_last[sel]=1;
    - (b) accepted beat with beat_cnt==HOLD_MAX-1 and req_last[sel]=0, which also sets hold_expired=1 next cycle;
    - (c) req[sel]=0, meaning the requester withdrew (no beat accepted that cycle).
  - On release: next state=IDLE, gnt=0, ptr=(sel+1) mod 32 (31 wraps to 0), beat_cnt=0. sel keeps its last value.
  - If (a) and (b) coincide, it is a normal release; hold_expired stays 0.
  - out_ready=0 stalls with no state change. Stall has no timeout.
- There is exactly one IDLE bubble cycle between consecutive grants; out_valid=0 during the bubble.
- Requests from non-granted requesters arriving or dropping during LOCKED have no effect until the next arbitration.
- Fairness:
  - After requester k is served, k has lowest priority in the next arbitration.
  - With all 32 requesting continuously, each is granted once per 32 grants, in increasing index order.
- req_last for non-granted requesters is ignored.
- hold_expired is high for exactly one cycle (the IDLE bubble cycle).

Test Plan:
- Reset then single requester: rst held 2 cycles, then req=0x0000_0010 with req_last[4]=1 and out_ready=1.
  - Cycle 1 after req: locked=1, sel=4, gnt=0x10, out_valid=1, out_last=1.
  - Next cycle: locked=0, gnt=0.
- Round-robin order: req=0xFFFF_FFFF, req_last=all 1, out_ready=1 constantly.
  - Grants occur in order sel=0,1,2,...,31,0, each separated by one IDLE cycle.
  - After 31, ptr wraps and sel=0.
- Burst and stall: requester 7 sends 4 beats with out_ready toggling 1,0,1,1,0,1 and req_last[7] high on the 4th beat.
  - Exactly 4 accepted beats; gnt=0x80 throughout.
  - Release after the 4th acceptance; ptr=8, so a pending req[3] and req[9] yield sel=9 next.
- HOLD_MAX cap: HOLD_MAX=16, requester 2 streams with req_last=0 and out_ready=1.
  - Forced release after the 16th beat; hold_expired pulses 1 cycle.
  - With req=0x0000_0006, next grant is sel=1 (search wraps from ptr=3).
- Withdrawal and mid-burst reset:
  - Requester 5 granted, drops req after 2 beats: release next cycle, ptr=6, hold_expired=0.
  - Separately, asserting rst while locked gives gnt=0, locked=0, out_valid=0 next cycle and ptr=0.

Source files
------------

// File: rtl/dl_rr_arb32.sv
// Round-robin arbiter/sequencer for a shared 32:1 datapath mux.
// Grants one requester at a time and holds the grant for a multi-beat
// transfer until its last beat, a withdrawal, or the beat cap forces release.
module dl_rr_arb32 #(
  parameter int unsigned NUM_REQ  = 32,
  parameter int unsigned SEL_BITS = 5,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  req_last,
  input  logic                out_ready,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [SEL_BITS-1:0] sel,
  output logic                out_valid,
  output logic                out_last,
  output logic                locked,
  output logic                hold_expired
);

  localparam int unsigned CNT_W = 8;
  // Beat count at which the next accepted beat hits the cap.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_MAX - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_BITS-1:0] r_sel;
  logic [SEL_BITS-1:0] w_sel_nxt;
  logic [SEL_BITS-1:0] r_ptr;
  logic [SEL_BITS-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    w_beat_cnt_nxt;
  logic                r_hold_exp;
  logic                w_hold_exp_nxt;

  logic [NUM_REQ-1:0]  w_rot;
  logic [SEL_BITS-1:0] w_ofs;
  logic [SEL_BITS-1:0] w_win;
  logic                w_cur_req;
  logic                w_cur_last;
  logic                w_accept;
  logic                w_at_cap;

  // Rotate requests so the current priority pointer lands at bit 0.
  assign w_rot = NUM_REQ'({req, req} >> r_ptr);

  // Lowest set bit of the rotated vector = offset of the winner from ptr.
  always_comb begin
    w_ofs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_ofs = SEL_BITS'(i);
    end
  end

  // 5-bit add wraps naturally, giving the modulo-32 winner index.
  assign w_win = w_ofs + r_ptr;

  assign w_cur_req  = req[r_sel];
  assign w_cur_last = req_last[r_sel];
  assign w_accept   = w_cur_req & out_ready;
  assign w_at_cap   = (r_beat_cnt == LAST_CNT);

  assign locked       = (r_state == ST_LOCKED);
  assign out_valid    = locked & w_cur_req;
  assign out_last     = locked & w_cur_last;
  assign gnt          = r_gnt;
  assign sel          = r_sel;
  assign hold_expired = r_hold_exp;

  // Next-state: arbitrate in IDLE, track beats and release conditions in LOCKED.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_gnt_nxt      = r_gnt;
    w_beat_cnt_nxt = r_beat_cnt;
    w_hold_exp_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt    = ST_LOCKED;
          w_sel_nxt      = w_win;
          w_gnt_nxt      = NUM_REQ'(1) << w_win;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (!w_cur_req || (w_accept && (w_cur_last || w_at_cap))) begin
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = '0;
          w_ptr_nxt      = r_sel + SEL_BITS'(1);
          w_beat_cnt_nxt = '0;
          // A last beat landing on the cap is a normal release.
          w_hold_exp_nxt = w_accept & ~w_cur_last & w_at_cap;
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
      r_hold_exp <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_hold_exp <= w_hold_exp_nxt;
    end
  end

endmodule
